// File: rtl/gate_checker.sv
// Exhaustive logic-gate tester: drives all four {a,b} vectors PASSES times,
// compares five gate responses and reports mismatch count, sticky flags and first failing vector.
module gate_checker #(
    parameter int unsigned PASSES = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       y_nand,
    input  logic       y_not,
    input  logic       y_and,
    input  logic       y_or,
    input  logic       y_xor,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [4:0] fail_vec,
    output logic [1:0] first_fail_idx
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(PASSES - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [CNT_W-1:0] pcnt, pcnt_nxt;
    logic             a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
    logic [7:0]       err_nxt;
    logic [4:0]       fail_nxt;
    logic [1:0]       ffi_nxt;

    logic [4:0] expected;
    logic [4:0] mism;
    logic [2:0] mism_cnt;
    logic [8:0] err_sum;

    // Gate response check, bit order {xor, or, and, not, nand}
    always_comb begin
        expected = {a ^ b, a | b, a & b, ~a, ~(a & b)};
        mism     = {y_xor, y_or, y_and, y_not, y_nand} ^ expected;
        mism_cnt = 3'(mism[0]) + 3'(mism[1]) + 3'(mism[2]) + 3'(mism[3]) + 3'(mism[4]);
        err_sum  = 9'(err_count) + 9'(mism_cnt);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        pcnt_nxt  = pcnt;
        done_nxt  = done;
        pass_nxt  = pass;
        err_nxt   = err_count;
        fail_nxt  = fail_vec;
        ffi_nxt   = first_fail_idx;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = DRIVE;
                    idx_nxt   = 2'd0;
                    pcnt_nxt  = '0;
                    done_nxt  = 1'b0;
                    pass_nxt  = 1'b0;
                    err_nxt   = 8'd0;
                    fail_nxt  = 5'd0;
                    ffi_nxt   = 2'd0;
                end
            end
            DRIVE: state_nxt = SAMPLE;
            SAMPLE: begin
                err_nxt  = err_sum[8] ? 8'hFF : err_sum[7:0];
                fail_nxt = fail_vec | mism;
                if (err_count == 8'd0 && mism != 5'd0) begin
                    ffi_nxt = idx;
                end
                if (idx != 2'd3) begin
                    idx_nxt   = idx + 2'd1;
                    state_nxt = DRIVE;
                end else if (pcnt < LAST_PASS) begin
                    idx_nxt   = 2'd0;
                    pcnt_nxt  = pcnt + CNT_W'(1);
                    state_nxt = DRIVE;
                end else begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_nxt == 8'd0);
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt       = (state_nxt == DRIVE) || (state_nxt == SAMPLE);
        {a_nxt, b_nxt} = busy_nxt ? idx_nxt : 2'd0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            idx            <= 2'd0;
            pcnt           <= '0;
            a              <= 1'b0;
            b              <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 8'd0;
            fail_vec       <= 5'd0;
            first_fail_idx <= 2'd0;
        end else begin
            state          <= state_nxt;
            idx            <= idx_nxt;
            pcnt           <= pcnt_nxt;
            a              <= a_nxt;
            b              <= b_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            pass           <= pass_nxt;
            err_count      <= err_nxt;
            fail_vec       <= fail_nxt;
            first_fail_idx <= ffi_nxt;
        end
    end

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: three instances (PASSES 1, 2, 13) share a configurable
// faulty-gate environment; results are checked against a truth-table reference model.
module tb_gate_checker;

    logic clock = 1'b0;
    logic reset_n;
    logic start;
    logic [14:0] cfg;  // 3-bit mode per gate: 0 ideal, 1 inverted, 2 stuck0, 3 stuck1, 4 wired to a|b

    always #5 clock = ~clock;

    logic       a_s[3], b_s[3], busy_s[3], done_s[3], pass_s[3];
    logic [7:0] err_s[3];
    logic [4:0] fv_s[3];
    logic [1:0] ffi_s[3];
    logic       yn[3], yt[3], ya[3], yo[3], yx[3];

    int checks = 0;
    int errors = 0;
    int r_err[3], r_fv[3], r_ffi[3], r_pass[3];

    function automatic int pv(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 13;
    endfunction

    // Environment gate model (possibly faulty)
    function automatic logic resp(input logic [14:0] c, input int g, input logic av, input logic bv);
        logic id;
        logic [2:0] m;
        case (g)
            0: id = ~(av & bv);
            1: id = ~av;
            2: id = av & bv;
            3: id = av | bv;
            default: id = av ^ bv;
        endcase
        m = c[g*3 +: 3];
        case (m)
            3'd1: return ~id;
            3'd2: return 1'b0;
            3'd3: return 1'b1;
            3'd4: return av | bv;
            default: return id;
        endcase
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_env
        assign yn[k] = resp(cfg, 0, a_s[k], b_s[k]);
        assign yt[k] = resp(cfg, 1, a_s[k], b_s[k]);
        assign ya[k] = resp(cfg, 2, a_s[k], b_s[k]);
        assign yo[k] = resp(cfg, 3, a_s[k], b_s[k]);
        assign yx[k] = resp(cfg, 4, a_s[k], b_s[k]);
    end

    gate_checker #(.PASSES(1)) u_p1 (
        .clock(clock), .reset_n(reset_n), .start(start), .a(a_s[0]), .b(b_s[0]),
        .y_nand(yn[0]), .y_not(yt[0]), .y_and(ya[0]), .y_or(yo[0]), .y_xor(yx[0]),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .err_count(err_s[0]),
        .fail_vec(fv_s[0]), .first_fail_idx(ffi_s[0])
    );
    gate_checker #(.PASSES(2)) u_p2 (
        .clock(clock), .reset_n(reset_n), .start(start), .a(a_s[1]), .b(b_s[1]),
        .y_nand(yn[1]), .y_not(yt[1]), .y_and(ya[1]), .y_or(yo[1]), .y_xor(yx[1]),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .err_count(err_s[1]),
        .fail_vec(fv_s[1]), .first_fail_idx(ffi_s[1])
    );
    gate_checker #(.PASSES(13)) u_p13 (
        .clock(clock), .reset_n(reset_n), .start(start), .a(a_s[2]), .b(b_s[2]),
        .y_nand(yn[2]), .y_not(yt[2]), .y_and(ya[2]), .y_or(yo[2]), .y_xor(yx[2]),
        .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]), .err_count(err_s[2]),
        .fail_vec(fv_s[2]), .first_fail_idx(ffi_s[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: count mismatches against truth tables indexed by {a,b}
    task automatic model(input logic [14:0] c, input int p, output int err, output int fv, output int ffi);
        logic [3:0] tt[5];
        logic [1:0] vv;
        tt = '{4'b0111, 4'b0011, 4'b1000, 4'b1110, 4'b0110};
        err = 0; fv = 0; ffi = -1;
        for (int q = 0; q < p; q++)
            for (int v = 0; v < 4; v++)
                for (int g = 0; g < 5; g++) begin
                    vv = 2'(v);
                    if (resp(c, g, vv[1], vv[0]) != tt[g][v]) begin
                        err++;
                        fv |= (1 << g);
                        if (ffi < 0) ffi = v;
                    end
                end
        if (err > 255) err = 255;
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s_p%0d", tag, pv(k)),
                32'({a_s[k], b_s[k], busy_s[k], done_s[k], pass_s[k], err_s[k], fv_s[k], ffi_s[k]}), 0);
    endtask

    // One run on all instances; checks stimulus/busy of PASSES=1 and exact done latency of each
    task automatic run_cfg(input logic [14:0] c, input bit repulse);
        cfg = c;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int n = 1; n <= 8 * 13 + 1; n++) begin
            @(posedge clock);
            #1;
            if (repulse) start = (n == 3);
            chk("ab_p1", 32'({a_s[0], b_s[0]}), (n < 8) ? (n / 2) : 0);
            chk("busy_p1", 32'(busy_s[0]), 32'(n < 8));
            for (int k = 0; k < 3; k++) begin
                if (n == 8 * pv(k) - 1) chk($sformatf("early_done_p%0d", pv(k)), 32'(done_s[k]), 0);
                if (n == 8 * pv(k)) begin
                    chk($sformatf("done_p%0d", pv(k)), 32'(done_s[k]), 1);
                    chk($sformatf("busy_end_p%0d", pv(k)), 32'(busy_s[k]), 0);
                    r_err[k]  = int'(err_s[k]);
                    r_fv[k]   = int'(fv_s[k]);
                    r_ffi[k]  = int'(ffi_s[k]);
                    r_pass[k] = int'(pass_s[k]);
                end
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [14:0] c;
        bit          rep;
        int          inst;
        int          err;
        int          fv;
        int          ffi;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int m_err, m_fv, m_ffi;
        logic [14:0] rc;

        vecs[0] = '{15'h0000, 1'b0, 0, 0,   5'b00000, 0};  // ideal gates
        vecs[1] = '{15'h4000, 1'b0, 0, 1,   5'b10000, 3};  // xor wired as or
        vecs[2] = '{15'h0002, 1'b0, 1, 6,   5'b00001, 0};  // nand stuck 0, 2 passes
        vecs[3] = '{15'h1249, 1'b0, 2, 255, 5'b11111, 0};  // all inverted, saturates
        vecs[4] = '{15'h0018, 1'b0, 0, 2,   5'b00010, 2};  // not stuck 1
        vecs[5] = '{15'h00C0, 1'b0, 1, 6,   5'b00100, 0};  // and stuck 1
        vecs[6] = '{15'h0000, 1'b1, 2, 0,   5'b00000, 0};  // start re-pulsed while busy

        reset_n = 1'b0;
        start   = 1'b0;
        cfg     = 15'h0;
        repeat (3) @(posedge clock);
        #1 check_all_zero("reset_hold");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1 check_all_zero("idle_after_reset");

        for (int i = 0; i < 7; i++) begin
            run_cfg(vecs[i].c, vecs[i].rep);
            chk($sformatf("vec%0d_err", i),  r_err[vecs[i].inst], vecs[i].err);
            chk($sformatf("vec%0d_fv", i),   r_fv[vecs[i].inst],  vecs[i].fv);
            chk($sformatf("vec%0d_pass", i), r_pass[vecs[i].inst], 32'(vecs[i].err == 0));
            if (vecs[i].err != 0) chk($sformatf("vec%0d_ffi", i), r_ffi[vecs[i].inst], vecs[i].ffi);
        end

        // Async reset while results are held in DONE
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_reset_done");
        @(negedge clock);
        reset_n = 1'b1;

        // Reset mid-run at idx 2 with faulty gates, then a clean run
        cfg = 15'h1249;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (4) @(posedge clock);
        #1 chk("midrun_ab_p1", 32'({a_s[0], b_s[0]}), 2);
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_reset_midrun");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1 check_all_zero("stays_idle");
        run_cfg(15'h0000, 1'b0);
        chk("after_abort_err", r_err[0], 0);
        chk("after_abort_pass", r_pass[0], 1);
        chk("after_abort_fv", r_fv[0], 0);

        // Start held high: back-to-back runs with one-cycle done
        cfg = 15'h0000;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        for (int n = 1; n <= 17; n++) begin
            @(posedge clock);
            #1;
            if (n == 8)  chk("b2b_done1", 32'(done_s[0]), 1);
            if (n == 9)  chk("b2b_gap_done", 32'(done_s[0]), 0);
            if (n == 9)  chk("b2b_gap_busy", 32'(busy_s[0]), 1);
            if (n == 16) chk("b2b_early_done2", 32'(done_s[0]), 0);
            if (n == 17) chk("b2b_done2", 32'(done_s[0]), 1);
            if (n == 17) chk("b2b_pass2", 32'(pass_s[0]), 1);
        end
        start = 1'b0;
        repeat (8 * 13 + 4) @(posedge clock);

        // Randomized fault configurations against the reference model
        for (int i = 0; i < 25; i++) begin
            rc = 15'h0;
            for (int g = 0; g < 5; g++)
                rc[g*3 +: 3] = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 4));
            run_cfg(rc, ($urandom_range(0, 3) == 0));
            for (int k = 0; k < 3; k++) begin
                model(rc, pv(k), m_err, m_fv, m_ffi);
                chk($sformatf("rnd%0d_err_p%0d", i, pv(k)),  r_err[k],  m_err);
                chk($sformatf("rnd%0d_fv_p%0d", i, pv(k)),   r_fv[k],   m_fv);
                chk($sformatf("rnd%0d_pass_p%0d", i, pv(k)), r_pass[k], 32'(m_err == 0));
                if (m_err != 0) chk($sformatf("rnd%0d_ffi_p%0d", i, pv(k)), r_ffi[k], m_ffi);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
